seven_segment_mux: RTL and testbench

Parametrised time-multiplexed driver for N-digit common-anode seven-segment displays. It is the successor to the fixed 8-digit BCD scanner and adds:
- digit count as a parameter
- full hex decode and per-digit decimal points
- per-digit enables and leading-zero blanking
- PWM brightness and anti-ghosting guard time
- frame-coherent input latching

It sits between score/debug logic and the board's cathode/anode pins.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/hex_to_seven_seg.sv | 13 +
 rtl/seven_segment_mux.sv | 127 ++++++++++++
 tb/tb_seven_segment_mux.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment constants.
//   SEG_A..SEG_G, SEG_DP : bit positions of each segment within cat_out
//   HEX_GLYPHS           : active-high glyphs for 0-F, bit 6 = A ... bit 0 = G
//   SEG_BLANK            : active-low cathode pattern with every segment off
package seg_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Glyph bit order matches cat_out[7:1], so a glyph bit for segment X
    // sits at index SEG_X-1. b and d are the lowercase forms.
    localparam logic [6:0] HEX_GLYPHS [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/hex_to_seven_seg.sv
// hex_to_seven_seg: combinational hex nibble to active-high segment decoder.
//   nibble : 4-bit value 0-F
//   seg    : active-high segments, bit 6 = A ... bit 0 = G
module hex_to_seven_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPHS[nibble];

endmodule

// File: rtl/seven_segment_mux.sv
// seven_segment_mux: time-multiplexed N-digit common-anode display driver.
//   clk_in        : system clock
//   rst_in        : synchronous active-high reset
//   val_in        : hex nibbles, digit i = val_in[4i+3:4i], digit 0 rightmost
//   dp_in         : decimal point request per digit
//   digit_en_in   : per-digit enable
//   lz_blank_in   : suppress leading zeros
//   brightness_in : PWM duty level, all-ones = full on
//   cat_out       : active-low cathodes, [7]=A ... [1]=G, [0]=DP
//   an_out        : active-low anodes, bit i = digit i
//   frame_out     : one-cycle pulse after the shadow registers load
module seven_segment_mux
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int REFRESH_CYCLES = 100000,
    parameter int GUARD_CYCLES   = 2,
    parameter int BRIGHT_BITS    = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    lz_blank_in,
    input  logic [BRIGHT_BITS-1:0]  brightness_in,
    output logic [7:0]              cat_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_out
);

    localparam int SW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_CYCLES - 1);
    localparam logic [SW-1:0] GUARD     = SW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [SW-1:0]           slot_cnt;
    logic [IW-1:0]           digit_idx;
    logic [BRIGHT_BITS-1:0]  pwm_cnt;
    logic [4*NUM_DIGITS-1:0] sh_val;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lz;
    logic [BRIGHT_BITS-1:0]  sh_br;

    logic                    slot_end;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    lit;
    logic [6:0]              seg;
    logic [7:0]              cat_next;

    assign slot_end  = slot_cnt == SLOT_LAST;
    assign frame_end = slot_end && digit_idx == IDX_LAST;
    assign cur_nib   = sh_val[{digit_idx, 2'b00} +: 4];
    assign cur_dp    = sh_dp[digit_idx];

    // Walk from the most significant digit down; a digit is a leading zero
    // only while every digit above it is also a bare zero (no DP).
    always_comb begin
        logic lead;
        lead = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead = lead && sh_val[4*i +: 4] == 4'h0 && !sh_dp[i];
            lz_mask[i] = sh_lz && (i != 0) && lead;
        end
    end

    assign lit = slot_cnt >= GUARD && pwm_cnt <= sh_br &&
                 sh_en[digit_idx] && !lz_mask[digit_idx];

    hex_to_seven_seg u_dec (
        .nibble (cur_nib),
        .seg    (seg)
    );

    always_comb begin
        cat_next = SEG_BLANK;
        if (lit) begin
            cat_next[SEG_A]  = ~seg[SEG_A-1];
            cat_next[SEG_B]  = ~seg[SEG_B-1];
            cat_next[SEG_C]  = ~seg[SEG_C-1];
            cat_next[SEG_D]  = ~seg[SEG_D-1];
            cat_next[SEG_E]  = ~seg[SEG_E-1];
            cat_next[SEG_F]  = ~seg[SEG_F-1];
            cat_next[SEG_G]  = ~seg[SEG_G-1];
            cat_next[SEG_DP] = ~cur_dp;
        end
    end

    // Shadows reload during reset so the first frame shows current inputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
            pwm_cnt   <= '0;
            an_out    <= '1;
            cat_out   <= SEG_BLANK;
            frame_out <= 1'b0;
            sh_val    <= val_in;
            sh_dp     <= dp_in;
            sh_en     <= digit_en_in;
            sh_lz     <= lz_blank_in;
            sh_br     <= brightness_in;
        end else begin
            slot_cnt  <= slot_end ? '0 : slot_cnt + 1'b1;
            if (slot_end)
                digit_idx <= digit_idx == IDX_LAST ? '0 : digit_idx + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            frame_out <= frame_end;
            an_out    <= lit ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
            cat_out   <= cat_next;
            if (frame_end) begin
                sh_val <= val_in;
                sh_dp  <= dp_in;
                sh_en  <= digit_en_in;
                sh_lz  <= lz_blank_in;
                sh_br  <= brightness_in;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// tb_seven_segment_mux: directed checks of the 4-digit, 8-cycle-slot configuration.
module tb_seven_segment_mux;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] val_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en_in = '1;
    logic        lz_blank_in = 1'b0;
    logic [1:0]  brightness_in = 2'd3;
    logic [7:0]  cat_out;
    logic [3:0]  an_out;
    logic        frame_out;

    int checks = 0;
    int errors = 0;

    seven_segment_mux #(
        .NUM_DIGITS     (4),
        .REFRESH_CYCLES (8),
        .GUARD_CYCLES   (2),
        .BRIGHT_BITS    (2)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .val_in        (val_in),
        .dp_in         (dp_in),
        .digit_en_in   (digit_en_in),
        .lz_blank_in   (lz_blank_in),
        .brightness_in (brightness_in),
        .cat_out       (cat_out),
        .an_out        (an_out),
        .frame_out     (frame_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [1:0]  br;
        int          t;
        logic [3:0]  an;
        logic [7:0]  cat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic set_inputs(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                              input logic lz, input logic [1:0] br);
        val_in = v;
        dp_in = dp;
        digit_en_in = en;
        lz_blank_in = lz;
        brightness_in = br;
    endtask

    // After this, counters hold 0; tick(t+1) then shows the outputs for counter cycle t.
    task automatic do_reset();
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
    endtask

    initial begin
        int pulses, first_pulse, second_pulse;
        int lit_cnt [4];

        // val, dp, en, lz, br, t, an, cat
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3,  0, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3,  1, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3,  2, 4'hE, 8'h71});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3,  7, 4'hE, 8'h71});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3,  8, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3, 10, 4'hD, 8'h11});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3, 18, 4'hB, 8'h25});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3, 26, 4'h7, 8'h9F});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 26, 4'hF, 8'hFF});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 18, 4'hF, 8'hFF});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 10, 4'hD, 8'h49});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3,  2, 4'hE, 8'h03});
        vecs.push_back('{16'h0050, 4'h4, 4'hF, 1'b1, 2'd3, 18, 4'hB, 8'h02});
        vecs.push_back('{16'h0050, 4'h4, 4'hF, 1'b1, 2'd3, 26, 4'hF, 8'hFF});
        vecs.push_back('{16'h0050, 4'h0, 4'hF, 1'b0, 2'd3, 26, 4'h7, 8'h03});
        vecs.push_back('{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3,  2, 4'hE, 8'h03});
        vecs.push_back('{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3, 10, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd0,  2, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd0,  4, 4'hE, 8'h71});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd0,  5, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd1,  5, 4'hE, 8'h71});
        vecs.push_back('{16'h12AF, 4'h0, 4'hF, 1'b0, 2'd1,  6, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'h5, 1'b0, 2'd3, 10, 4'hF, 8'hFF});
        vecs.push_back('{16'h12AF, 4'h0, 4'h5, 1'b0, 2'd3, 18, 4'hB, 8'h25});
        vecs.push_back('{16'h12AF, 4'h0, 4'h5, 1'b0, 2'd3, 26, 4'hF, 8'hFF});
        vecs.push_back('{16'h8DCE, 4'h1, 4'hF, 1'b0, 2'd3,  2, 4'hE, 8'h60});
        vecs.push_back('{16'h8DCE, 4'h1, 4'hF, 1'b0, 2'd3, 10, 4'hD, 8'h63});
        vecs.push_back('{16'h8DCE, 4'h1, 4'hF, 1'b0, 2'd3, 18, 4'hB, 8'h85});
        vecs.push_back('{16'h8DCE, 4'h1, 4'hF, 1'b0, 2'd3, 26, 4'h7, 8'h01});

        // Reset state
        set_inputs(16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3);
        rst_in = 1'b1;
        tick(1);
        check("reset_an", 32'(an_out), 32'hF);
        check("reset_cat", 32'(cat_out), 32'hFF);
        check("reset_frame", 32'(frame_out), 32'h0);

        foreach (vecs[n]) begin
            set_inputs(vecs[n].val, vecs[n].dp, vecs[n].en, vecs[n].lz, vecs[n].br);
            do_reset();
            tick(vecs[n].t + 1);
            check($sformatf("vec%0d_an", n), 32'(an_out), 32'(vecs[n].an));
            check($sformatf("vec%0d_cat", n), 32'(cat_out), 32'(vecs[n].cat));
        end

        // Full scan: frame pulse timing, lit cycles per digit, one anode at a time
        set_inputs(16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3);
        do_reset();
        pulses = 0;
        first_pulse = -1;
        second_pulse = -1;
        for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
        for (int k = 1; k <= 70; k++) begin
            tick(1);
            if (frame_out) begin
                pulses++;
                if (pulses == 1) first_pulse = k;
                if (pulses == 2) second_pulse = k;
            end
            check("one_anode", 32'($countones(~an_out) <= 1), 32'h1);
            if (k <= 32)
                for (int d = 0; d < 4; d++)
                    if (!an_out[d]) lit_cnt[d]++;
        end
        check("frame_first", 32'(first_pulse), 32);
        check("frame_second", 32'(second_pulse), 64);
        check("frame_count", 32'(pulses), 2);
        for (int d = 0; d < 4; d++)
            check($sformatf("lit_cycles_d%0d", d), 32'(lit_cnt[d]), 6);

        // Frame coherence: change inputs while digit 1 is scanning
        set_inputs(16'h1111, 4'h0, 4'hF, 1'b0, 2'd3);
        do_reset();
        tick(10);
        val_in = 16'h2222;
        tick(1);
        check("coh_d1_an", 32'(an_out), 32'hD);
        check("coh_d1_cat", 32'(cat_out), 32'h9F);
        tick(16);
        check("coh_d3_an", 32'(an_out), 32'h7);
        check("coh_d3_cat", 32'(cat_out), 32'h9F);
        tick(5);
        check("coh_frame", 32'(frame_out), 32'h1);
        tick(3);
        check("coh_new_d0_an", 32'(an_out), 32'hE);
        check("coh_new_d0_cat", 32'(cat_out), 32'h25);
        tick(16);
        check("coh_new_d2_an", 32'(an_out), 32'hB);
        check("coh_new_d2_cat", 32'(cat_out), 32'h25);

        // Reset mid-slot at digit 2, slot 5
        set_inputs(16'h12AF, 4'h0, 4'hF, 1'b0, 2'd3);
        do_reset();
        tick(21);
        check("pre_rst_an", 32'(an_out), 32'hB);
        rst_in = 1'b1;
        tick(1);
        check("mid_rst_an", 32'(an_out), 32'hF);
        check("mid_rst_cat", 32'(cat_out), 32'hFF);
        check("mid_rst_frame", 32'(frame_out), 32'h0);
        rst_in = 1'b0;
        tick(1);
        check("restart_guard0", 32'(an_out), 32'hF);
        tick(1);
        check("restart_guard1", 32'(an_out), 32'hF);
        tick(1);
        check("restart_d0_an", 32'(an_out), 32'hE);
        check("restart_d0_cat", 32'(cat_out), 32'h71);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
